regfile_wb_arbiter: RTL

//  Shares the register file's single write port between NUM_SRC writeback sources
//  (src 0 = ALU, 1 = load/store, 2 = mul/div) using round-robin arbitration.

---
 rtl/raisin64_rf_pkg.sv | 17 +
 rtl/regfile_wb_arbiter_if.sv | 37 +++
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 56 +++++
 rtl/regfile_wb_arbiter.sv | 94 +++++++++
 4 files changed

// File: rtl/raisin64_rf_pkg.sv
// Shared register-file definitions for the raisin64 core: register numbering,
// writeback source IDs and a small round-robin index helper.
package raisin64_rf_pkg;

    localparam int RF_RN_W  = 6;
    localparam int RF_NREGS = 64;

    localparam int SRC_ALU = 0;
    localparam int SRC_LSU = 1;
    localparam int SRC_MDU = 2;

    // Wrap an index that has run at most one lap past n back into 0..n-1.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between execution units / issue stage and the regfile write arbiter.
interface regfile_wb_arbiter_if #(
    parameter int NUM_SRC = 3,
    parameter int DATA_W  = 64,
    parameter int RN_W    = 6
);
    localparam int PTR_W = $clog2(NUM_SRC);

    // A source transfers when src_valid[i] && src_ready[i]; it keeps src_rn/src_data
    // stable while valid and may drop or replace its request only after the transfer.
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC-1:0]        src_ready;
    logic [NUM_SRC*RN_W-1:0]   src_rn;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic                      wb_hold;
    logic                      w_en;
    logic [RN_W-1:0]           w_rn;
    logic [DATA_W-1:0]         w_data;
    logic                      sb_set;
    logic [RN_W-1:0]           sb_rn;
    logic [RN_W-1:0]           chk1_rn;
    logic [RN_W-1:0]           chk2_rn;
    logic                      hazard;
    logic [2**RN_W-1:0]        busy_vec;
    logic [PTR_W-1:0]          rr_ptr;

    modport master (
        output src_valid, src_rn, src_data, wb_hold, sb_set, sb_rn, chk1_rn, chk2_rn,
        input  src_ready, w_en, w_rn, w_data, hazard, busy_vec, rr_ptr
    );

    modport slave (
        input  src_valid, src_rn, src_data, wb_hold, sb_set, sb_rn, chk1_rn, chk2_rn,
        output src_ready, w_en, w_rn, w_data, hazard, busy_vec, rr_ptr
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, search starts at the pointer,
// pointer moves one past the winner; hold_i suppresses grants and freezes the pointer.
module rr_arbiter
    import raisin64_rf_pkg::*;
#(
    parameter  int N     = 3,
    localparam int PTR_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_i,
    input  logic             hold_i,
    output logic [N-1:0]     gnt_o,
    output logic [PTR_W-1:0] gnt_idx_o,
    output logic             gnt_vld_o,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        idx       = '0;
        if (!hold_i) begin
            for (int k = 0; k < N; k++) begin
                idx = PTR_W'(rr_wrap(int'(ptr_q) + k, N));
                if (!gnt_vld_o && req_i[idx]) begin
                    gnt_vld_o  = 1'b1;
                    gnt_o[idx] = 1'b1;
                    gnt_idx_o  = idx;
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld_o) begin
            ptr_d = PTR_W'(rr_wrap(int'(gnt_idx_o) + 1, N));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between NUM_SRC writeback sources and tracks
// in-flight destination registers to flag read-after-write hazards for issue.
module regfile_wb_arbiter
    import raisin64_rf_pkg::*;
#(
    parameter  int NUM_SRC = 3,
    parameter  int DATA_W  = 64,
    parameter  int RN_W    = RF_RN_W,
    localparam int PTR_W   = $clog2(NUM_SRC),
    localparam int NREGS   = 2**RN_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  wb
);

    logic [NUM_SRC-1:0] gnt;
    logic [PTR_W-1:0]   gnt_idx;
    logic               gnt_vld;
    logic [PTR_W-1:0]   rr_ptr;

    logic               w_en_q, w_en_d;
    logic [RN_W-1:0]    w_rn_q, w_rn_d;
    logic [DATA_W-1:0]  w_data_q, w_data_d;
    logic [NREGS-1:0]   busy_q, busy_d;

    logic [RN_W-1:0]    sel_rn;
    logic [DATA_W-1:0]  sel_data;
    logic               chk1_haz, chk2_haz;

    // Reset doubles as a hold so no grant is visible while rst_n is low.
    rr_arbiter #(.N(NUM_SRC)) u_rr_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (wb.src_valid),
        .hold_i    (wb.wb_hold || !rst_n),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld),
        .ptr_o     (rr_ptr)
    );

    assign sel_rn   = wb.src_rn[int'(gnt_idx)*RN_W +: RN_W];
    assign sel_data = wb.src_data[int'(gnt_idx)*DATA_W +: DATA_W];

    // An r0 transfer completes its handshake but never reaches the regfile.
    always_comb begin
        w_en_d   = gnt_vld && (sel_rn != '0);
        w_rn_d   = w_rn_q;
        w_data_d = w_data_q;
        if (w_en_d) begin
            w_rn_d   = sel_rn;
            w_data_d = sel_data;
        end
    end

    // Set is applied after clear so a newly issued producer keeps its register busy.
    always_comb begin
        busy_d = busy_q;
        if (w_en_q) begin
            busy_d[w_rn_q] = 1'b0;
        end
        if (wb.sb_set && (wb.sb_rn != '0)) begin
            busy_d[wb.sb_rn] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_en_q   <= 1'b0;
            w_rn_q   <= '0;
            w_data_q <= '0;
            busy_q   <= '0;
        end else begin
            w_en_q   <= w_en_d;
            w_rn_q   <= w_rn_d;
            w_data_q <= w_data_d;
            busy_q   <= busy_d;
        end
    end

    // The register being written this cycle is served by the regfile bypass.
    assign chk1_haz = busy_q[wb.chk1_rn] && !(w_en_q && (w_rn_q == wb.chk1_rn));
    assign chk2_haz = busy_q[wb.chk2_rn] && !(w_en_q && (w_rn_q == wb.chk2_rn));

    assign wb.src_ready = gnt;
    assign wb.w_en      = w_en_q;
    assign wb.w_rn      = w_rn_q;
    assign wb.w_data    = w_data_q;
    assign wb.hazard    = chk1_haz || chk2_haz;
    assign wb.busy_vec  = busy_q;
    assign wb.rr_ptr    = rr_ptr;

endmodule
